// File: rtl/if_else_raw_array_pkg.sv
// Shared types and encodings for the if-else read-add-write state array.
package if_else_raw_array_pkg;

    typedef logic [1:0] int2_t;

    // Relational opcodes; all compares are unsigned.
    localparam int2_t REL_NE = 2'd0;
    localparam int2_t REL_LT = 2'd1;
    localparam int2_t REL_GT = 2'd2;
    localparam int2_t REL_EQ = 2'd3;

    // mux3 selects; the value 3 also selects the constant operand.
    localparam int2_t MUX3_PKT1 = 2'd0;
    localparam int2_t MUX3_PKT2 = 2'd1;
    localparam int2_t MUX3_CONS = 2'd2;

endpackage

// File: rtl/if_else_raw_array_if.sv
// Packet-in / result-out bundle for the state array. The packet side has no ready.
// A packet is accepted on every posedge where in_valid=1. A result is valid on every posedge where out_valid=1.
interface if_else_raw_array_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    import if_else_raw_array_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);

    logic              in_valid;
    logic [IDX_W-1:0]  in_idx;
    logic [WIDTH-1:0]  pkt_1;
    logic [WIDTH-1:0]  pkt_2;
    logic [WIDTH-1:0]  cons_1;
    logic [WIDTH-1:0]  cons_2;
    logic [WIDTH-1:0]  cons_3;
    logic              sel_1;
    int2_t             sel_2;
    logic              sel_3;
    int2_t             sel_4;
    logic              sel_5;
    int2_t             sel_6;
    int2_t             rel_opcode;
    logic              out_valid;
    logic [IDX_W-1:0]  out_idx;
    logic [WIDTH-1:0]  o__read;
    logic [WIDTH-1:0]  o__write;

    modport master (
        output in_valid, in_idx, pkt_1, pkt_2, cons_1, cons_2, cons_3,
        output sel_1, sel_2, sel_3, sel_4, sel_5, sel_6, rel_opcode,
        input  out_valid, out_idx, o__read, o__write
    );

    modport slave (
        input  in_valid, in_idx, pkt_1, pkt_2, cons_1, cons_2, cons_3,
        input  sel_1, sel_2, sel_3, sel_4, sel_5, sel_6, rel_opcode,
        output out_valid, out_idx, o__read, o__write
    );

endinterface

// File: rtl/if_else_raw_array_alu.sv
// Combinational second-stage compute: compare selects the then/else addend pair.
// The selected pair is then summed, with optional unsigned saturation.
module if_else_raw_array_alu
    import if_else_raw_array_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] s_i,
    input  logic [WIDTH-1:0] pkt_1_i,
    input  logic [WIDTH-1:0] pkt_2_i,
    input  logic [WIDTH-1:0] cons_1_i,
    input  logic [WIDTH-1:0] cons_2_i,
    input  logic [WIDTH-1:0] cons_3_i,
    input  logic             sel_1_i,
    input  int2_t            sel_2_i,
    input  logic             sel_3_i,
    input  int2_t            sel_4_i,
    input  logic             sel_5_i,
    input  int2_t            sel_6_i,
    input  int2_t            rel_opcode_i,
    output logic [WIDTH-1:0] nv_o
);

    function automatic logic [WIDTH-1:0] mux2(input logic sel, input logic [WIDTH-1:0] s);
        return sel ? '0 : s;
    endfunction

    function automatic logic [WIDTH-1:0] mux3(input int2_t sel, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c);
        if (sel == MUX3_PKT1) return a;
        else if (sel == MUX3_PKT2) return b;
        else return c;
    endfunction

    logic [WIDTH-1:0] lhs;
    logic [WIDTH-1:0] rhs;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] addend;
    logic             cond;
    logic [WIDTH:0]   sum;

    always_comb begin
        lhs = mux2(sel_1_i, s_i);
        rhs = mux3(sel_2_i, pkt_1_i, pkt_2_i, cons_1_i);
        case (rel_opcode_i)
            REL_NE:  cond = (lhs != rhs);
            REL_LT:  cond = (lhs < rhs);
            REL_GT:  cond = (lhs > rhs);
            default: cond = (lhs == rhs);
        endcase

        if (cond) begin
            base   = mux2(sel_3_i, s_i);
            addend = mux3(sel_4_i, pkt_1_i, pkt_2_i, cons_2_i);
        end else begin
            base   = mux2(sel_5_i, s_i);
            addend = mux3(sel_6_i, pkt_1_i, pkt_2_i, cons_3_i);
        end

        // Carry out of the extra bit drives the clamp.
        sum = {1'b0, base} + {1'b0, addend};
        if ((SATURATE != 0) && sum[WIDTH]) nv_o = '1;
        else nv_o = sum[WIDTH-1:0];
    end

endmodule

// File: rtl/if_else_raw_array.sv
// Two-stage read-add-write over a DEPTH-entry state array, one packet per clock.
// A same-index packet directly behind its predecessor takes the bypassed result.
module if_else_raw_array
    import if_else_raw_array_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int SATURATE = 0
) (
    input logic             clk,
    input logic             rst_n,
    if_else_raw_array_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             s1_valid_q;
    logic [IDX_W-1:0] s1_idx_q;
    logic [WIDTH-1:0] s1_s_q;
    logic [WIDTH-1:0] s1_pkt_1_q, s1_pkt_2_q;
    logic [WIDTH-1:0] s1_cons_1_q, s1_cons_2_q, s1_cons_3_q;
    logic             s1_sel_1_q, s1_sel_3_q, s1_sel_5_q;
    int2_t            s1_sel_2_q, s1_sel_4_q, s1_sel_6_q, s1_rel_q;

    logic             out_valid_q;
    logic [IDX_W-1:0] out_idx_q;
    logic [WIDTH-1:0] out_read_q;
    logic [WIDTH-1:0] out_write_q;

    logic [WIDTH-1:0] nv_d;
    logic [WIDTH-1:0] s_d;

    // The stage-2 write lands on the same edge as this read, so take it from the ALU.
    always_comb begin
        if (s1_valid_q && (s1_idx_q == bus.in_idx)) s_d = nv_d;
        else s_d = mem_q[bus.in_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_idx_q    <= '0;
            s1_s_q      <= '0;
            s1_pkt_1_q  <= '0;
            s1_pkt_2_q  <= '0;
            s1_cons_1_q <= '0;
            s1_cons_2_q <= '0;
            s1_cons_3_q <= '0;
            s1_sel_1_q  <= 1'b0;
            s1_sel_3_q  <= 1'b0;
            s1_sel_5_q  <= 1'b0;
            s1_sel_2_q  <= '0;
            s1_sel_4_q  <= '0;
            s1_sel_6_q  <= '0;
            s1_rel_q    <= '0;
        end else begin
            s1_valid_q  <= bus.in_valid;
            s1_idx_q    <= bus.in_idx;
            s1_s_q      <= s_d;
            s1_pkt_1_q  <= bus.pkt_1;
            s1_pkt_2_q  <= bus.pkt_2;
            s1_cons_1_q <= bus.cons_1;
            s1_cons_2_q <= bus.cons_2;
            s1_cons_3_q <= bus.cons_3;
            s1_sel_1_q  <= bus.sel_1;
            s1_sel_3_q  <= bus.sel_3;
            s1_sel_5_q  <= bus.sel_5;
            s1_sel_2_q  <= bus.sel_2;
            s1_sel_4_q  <= bus.sel_4;
            s1_sel_6_q  <= bus.sel_6;
            s1_rel_q    <= bus.rel_opcode;
        end
    end

    if_else_raw_array_alu #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_alu (
        .s_i          (s1_s_q),
        .pkt_1_i      (s1_pkt_1_q),
        .pkt_2_i      (s1_pkt_2_q),
        .cons_1_i     (s1_cons_1_q),
        .cons_2_i     (s1_cons_2_q),
        .cons_3_i     (s1_cons_3_q),
        .sel_1_i      (s1_sel_1_q),
        .sel_2_i      (s1_sel_2_q),
        .sel_3_i      (s1_sel_3_q),
        .sel_4_i      (s1_sel_4_q),
        .sel_5_i      (s1_sel_5_q),
        .sel_6_i      (s1_sel_6_q),
        .rel_opcode_i (s1_rel_q),
        .nv_o         (nv_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (s1_valid_q) begin
            mem_q[s1_idx_q] <= nv_d;
        end
    end

    // Data outputs keep their last values across bubbles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_read_q  <= '0;
            out_write_q <= '0;
        end else if (s1_valid_q) begin
            out_valid_q <= 1'b1;
            out_idx_q   <= s1_idx_q;
            out_read_q  <= s1_s_q;
            out_write_q <= nv_d;
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.o__read   = out_read_q;
    assign bus.o__write  = out_write_q;

endmodule
